uart_tx_arb: RTL and testbench

Round-robin arbiter that shares one `uart_delay` channel between `N` UART transmitters. It grants the channel to one requester at a time and routes that requester's serial stream into the delay block's `txsdi`. It also loads that requester's delay value onto `dv`. It switches sources only after the delay line has drained and the line has idled for a guard interval. It sits between the per-lane UART TX cores and the single `uart_delay` instance that drives the shared pin.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx_arb_if.sv | 26 ++
 rtl/rr_pick.sv | 28 ++
 rtl/uart_tx_arb.sv | 101 ++++++++++
 tb/tb_uart_tx_arb.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM states and the delay-value width used by uart_delay.
package uart_pkg;

    localparam int unsigned UART_DVW       = 11;
    localparam int unsigned UART_GUARD_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Bundle between the per-lane UART TX cores and the channel arbiter.
interface uart_tx_arb_if
    import uart_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned DVW = UART_DVW
);
    logic [N-1:0]     req;
    logic [N-1:0]     txd;
    logic [N*DVW-1:0] dv_cfg;
    logic [N-1:0]     gnt;
    logic             dly_txsdi;
    logic [DVW-1:0]   dly_dv;
    logic             busy;
    logic             abort;

    modport master (
        output req, txd, dv_cfg,
        input  gnt, dly_txsdi, dly_dv, busy, abort
    );

    modport slave (
        input  req, txd, dv_cfg,
        output gnt, dly_txsdi, dly_dv, busy, abort
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin first-one finder: lowest asserted index at or after i_ptr, wrapping.
module rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = 2
) (
    input  logic [N-1:0]    i_req,
    input  logic [SELW-1:0] i_ptr,
    output logic [SELW-1:0] o_sel,
    output logic            o_found
);

    int unsigned v_idx;

    // Scan N positions starting at the pointer; the first hit wins.
    always_comb begin
        o_sel   = '0;
        o_found = 1'b0;
        v_idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            v_idx = (32'(i_ptr) + k) % N;
            if (!o_found && i_req[SELW'(v_idx)]) begin
                o_found = 1'b1;
                o_sel   = SELW'(v_idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_delay channel between N UART transmitters.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned DVW   = UART_DVW,
    parameter int unsigned GUARD = UART_GUARD_DEF
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_arb_if.slave  io_bus
);

    localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW   = DVW + 9;

    arb_state_t       r_state;
    logic [SELW-1:0]  r_sel;
    logic [SELW-1:0]  r_ptr;
    logic [N-1:0]     r_gnt;
    logic             r_txsdi;
    logic [DVW-1:0]   r_dv;
    logic             r_busy;
    logic             r_abort;
    logic [CW-1:0]    r_drain;

    logic [SELW-1:0]  w_sel;
    logic             w_found;

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_pick (
        .i_req   (io_bus.req),
        .i_ptr   (r_ptr),
        .o_sel   (w_sel),
        .o_found (w_found)
    );

    // Arbitration FSM with registered grant, data mux, delay value and drain counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_txsdi <= 1'b1;
            r_dv    <= '0;
            r_busy  <= 1'b0;
            r_abort <= 1'b0;
            r_drain <= '0;
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_sel   <= w_sel;
                        r_gnt   <= N'(1) << w_sel;
                        r_dv    <= io_bus.dv_cfg[32'(w_sel)*DVW +: DVW];
                        r_busy  <= 1'b1;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!io_bus.req[r_sel]) begin
                        // Release: idle the line and wait for the delay line plus guard.
                        r_gnt   <= '0;
                        r_txsdi <= 1'b1;
                        r_drain <= CW'(r_dv) + CW'(GUARD);
                        r_abort <= ~io_bus.txd[r_sel];
                        r_state <= ST_DRAIN;
                    end else begin
                        r_txsdi <= io_bus.txd[r_sel];
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == '0) begin
                        r_ptr   <= (32'(r_sel) == N - 1) ? '0 : r_sel + SELW'(1);
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_drain <= r_drain - CW'(1);
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_txsdi <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_bus.gnt       = r_gnt;
    assign io_bus.dly_txsdi = r_txsdi;
    assign io_bus.dly_dv    = r_dv;
    assign io_bus.busy      = r_busy;
    assign io_bus.abort     = r_abort;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb (N=4, DVW=11, GUARD=16).
`timescale 1ns/1ps
module tb_uart_tx_arb;
    import uart_pkg::*;

    localparam int unsigned N     = 4;
    localparam int unsigned DVW   = 11;
    localparam int unsigned GUARD = 16;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    uart_tx_arb_if #(.N(N), .DVW(DVW)) bus ();

    uart_tx_arb #(.N(N), .DVW(DVW), .GUARD(GUARD)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_dv(input int lane, input int val);
        bus.dv_cfg[lane*DVW +: DVW] = DVW'(val);
    endtask

    // Wait (bounded) until some grant appears.
    task automatic wait_gnt();
        int c;
        c = 0;
        while (bus.gnt == '0 && c < 500) begin
            tick(1);
            c++;
        end
    endtask

    // Count cycles busy stays high, starting with the current cycle.
    task automatic measure_busy(output int n);
        n = 0;
        while (bus.busy && n < 2000) begin
            n++;
            tick(1);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_gnt"},   32'(bus.gnt),       32'd0);
        chk({tag, "_txsdi"}, 32'(bus.dly_txsdi), 32'd1);
        chk({tag, "_dv"},    32'(bus.dly_dv),    32'd0);
        chk({tag, "_busy"},  32'(bus.busy),      32'd0);
        chk({tag, "_abort"}, 32'(bus.abort),     32'd0);
    endtask

    initial begin
        logic [7:0] pat;
        int         ord [5];
        int         cnt;
        int         bad;
        int         aborts;

        n_tests = 0;
        n_fail  = 0;
        pat     = 8'b1001_0110;
        ord     = '{0, 1, 2, 3, 0};

        rst        = 1'b0;
        bus.req    = '0;
        bus.txd    = '1;
        bus.dv_cfg = '0;
        set_dv(0, 10);
        set_dv(1, 20);
        set_dv(2, 100);
        set_dv(3, 30);
        tick(3);
        check_reset_vals("rst");
        rst = 1'b1;
        tick(1);

        // Single requester on lane 2 with delay 100.
        bus.req = 4'b0100;
        tick(1);
        chk("t1_gnt",   32'(bus.gnt),       32'b0100);
        chk("t1_dv",    32'(bus.dly_dv),    32'd100);
        chk("t1_busy",  32'(bus.busy),      32'd1);
        chk("t1_txidl", 32'(bus.dly_txsdi), 32'd1);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            bus.txd[2] = pat[i];
            tick(1);
            if (bus.dly_txsdi !== pat[i]) bad++;
        end
        chk("t1_mirror_errs", 32'(bad), 32'd0);
        bus.txd[2] = 1'b1;
        tick(1);
        bus.req = '0;
        tick(1);
        chk("t1_rel_gnt",   32'(bus.gnt),       32'd0);
        chk("t1_rel_txsdi", 32'(bus.dly_txsdi), 32'd1);
        chk("t1_rel_abort", 32'(bus.abort),     32'd0);
        measure_busy(cnt);
        chk("t1_busy_len", 32'(cnt), 32'd117);
        chk("t1_dv_hold",  32'(bus.dly_dv), 32'd100);

        // Round-robin from a fresh pointer, all four lanes requesting.
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        bus.req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            wait_gnt();
            chk($sformatf("t2_gnt%0d", r), 32'(bus.gnt), 32'(4'b0001 << ord[r]));
            bad = 0;
            for (int c = 0; c < 50; c++) begin
                if (bus.gnt !== 4'(4'b0001 << ord[r])) bad++;
                tick(1);
            end
            chk($sformatf("t2_hold%0d", r), 32'(bad), 32'd0);
            bus.req[ord[r]] = 1'b0;
            tick(1);
            chk($sformatf("t2_rel%0d", r), 32'(bus.gnt), 32'd0);
            if (r < 4) bus.req[ord[r]] = 1'b1;
        end
        bus.req = '0;
        measure_busy(cnt);

        // Lane 1 finishes (pointer moves to 2), then lanes 0 and 1 contend.
        bus.req = 4'b0010;
        wait_gnt();
        chk("t3_gnt1", 32'(bus.gnt), 32'b0010);
        tick(5);
        bus.req = '0;
        tick(1);
        bus.req = 4'b0011;
        wait_gnt();
        chk("t3_wrap0", 32'(bus.gnt), 32'b0001);
        tick(3);
        bus.req = 4'b0010;
        tick(1);
        chk("t3_rel0", 32'(bus.gnt), 32'd0);
        wait_gnt();
        chk("t3_then1", 32'(bus.gnt), 32'b0010);

        // Abort: release lane 1 while its line is low.
        bus.txd[1] = 1'b0;
        tick(1);
        chk("t4_low", 32'(bus.dly_txsdi), 32'd0);
        bus.req = '0;
        tick(1);
        chk("t4_gnt",   32'(bus.gnt),       32'd0);
        chk("t4_txsdi", 32'(bus.dly_txsdi), 32'd1);
        chk("t4_abort", 32'(bus.abort),     32'd1);
        bus.txd[1] = 1'b1;
        tick(1);
        chk("t4_abort_end", 32'(bus.abort), 32'd0);
        aborts = 0;
        cnt    = 0;
        while (bus.busy && cnt < 2000) begin
            if (bus.abort) aborts++;
            cnt++;
            tick(1);
        end
        chk("t4_extra_aborts", 32'(aborts), 32'd0);

        // Config change mid-grant must not reach dly_dv (pointer now 2, lane 0 wraps in).
        bus.req = 4'b0001;
        wait_gnt();
        chk("t5_gnt", 32'(bus.gnt),    32'b0001);
        chk("t5_dv",  32'(bus.dly_dv), 32'd10);
        set_dv(0, 500);
        tick(5);
        chk("t5_dv_mid", 32'(bus.dly_dv), 32'd10);
        bus.req = '0;
        tick(1);
        measure_busy(cnt);
        chk("t5_busy_len", 32'(cnt), 32'd27);
        chk("t5_dv_idle",  32'(bus.dly_dv), 32'd10);

        // Reset in the middle of a drain (pointer now 1, lane 3 granted).
        bus.req = 4'b1000;
        wait_gnt();
        chk("t6_gnt3", 32'(bus.gnt),    32'b1000);
        chk("t6_dv",   32'(bus.dly_dv), 32'd30);
        tick(3);
        bus.req = '0;
        tick(5);
        chk("t6_draining", 32'(bus.busy), 32'd1);
        bus.req = 4'b0110;
        rst = 1'b0;
        #1;
        check_reset_vals("t6_async");
        tick(3);
        check_reset_vals("t6_held");
        rst = 1'b1;
        tick(1);
        chk("t6_next_gnt", 32'(bus.gnt),    32'b0010);
        chk("t6_next_dv",  32'(bus.dly_dv), 32'd20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
